// File: rtl/data_mem_sweep.sv
// data_mem_sweep: parametrised single-port data memory with a ready/valid
// request port, a registered read path, and a sequential clear sweep.
// The sweep zeroes the array after reset or clr, so the array has no reset
// path of its own. The low N_TAP words are exported on a debug tap bus.
module data_mem_sweep #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int N_TAP  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       din,
  input  logic                    clr,
  output logic                    ready,
  output logic                    rvalid,
  output logic [DATA_W-1:0]       dout,
  output logic                    busy,
  output logic [N_TAP*DATA_W-1:0] taps
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_acc, wr_acc;

  // Request handshake: nothing is accepted while sweeping or when a clear
  // is being requested in the same cycle.
  assign ready  = (state == IDLE) && !clr;
  assign busy   = (state == CLEAR);
  assign wr_acc = req && ready && we;
  assign rd_acc = req && ready && !we;

  // State and sweep counter register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Next-state logic: step the sweep, leave it after the last word, and
  // restart it from word 0 when clr arrives in IDLE.
  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      CLEAR: begin
        clr_addr_nxt = clr_addr + ADDR_W'(1);
        if (&clr_addr) state_nxt = IDLE;
      end
      IDLE: begin
        if (clr) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      default: begin
        state_nxt    = CLEAR;
        clr_addr_nxt = '0;
      end
    endcase
  end

  // Array write port: sweep writes zero, otherwise accepted writes land.
  // NOTE: the array deliberately has no reset so it can map onto block RAM;
  // its contents become defined only through the clear sweep.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[addr] <= din;
    end
  end

  // Registered read path: one-cycle latency, dout holds until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      dout   <= '0;
    end else begin
      rvalid <= rd_acc;
      if (rd_acc) dout <= mem[addr];
    end
  end

  // Debug taps: combinational view of the lowest N_TAP words.
  for (genvar k = 0; k < N_TAP; k++) begin : g_tap
    assign taps[k*DATA_W +: DATA_W] = mem[k];
  end

endmodule

// File: tb/tb_data_mem_sweep.sv
// Testbench for data_mem_sweep: default 8x256 instance checked against a
// reference array and a read scoreboard, plus a 16x16 parameter-corner instance.
module tb_data_mem_sweep;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, clr = 1'b0;
  logic [7:0]  addr = '0, din = '0;
  logic        ready, rvalid, busy;
  logic [7:0]  dout;
  logic [63:0] taps;

  logic         p_req = 1'b0, p_we = 1'b0, p_clr = 1'b0;
  logic [3:0]   p_addr = '0;
  logic [15:0]  p_din = '0;
  logic         p_ready, p_rvalid, p_busy;
  logic [15:0]  p_dout;
  logic [255:0] p_taps;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model [DEPTH];

  data_mem_sweep dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din),
    .clr(clr), .ready(ready), .rvalid(rvalid), .dout(dout), .busy(busy),
    .taps(taps)
  );

  data_mem_sweep #(.DATA_W(16), .ADDR_W(4), .N_TAP(16)) dut_p (
    .clk(clk), .rst(rst), .req(p_req), .we(p_we), .addr(p_addr), .din(p_din),
    .clr(p_clr), .ready(p_ready), .rvalid(p_rvalid), .dout(p_dout),
    .busy(p_busy), .taps(p_taps)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Read scoreboard: each accepted read is due exactly one edge after issue.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      checks++;
      if (rvalid !== 1'b1 || dout !== q[0].data) begin
        errors++;
        $display("FAIL read_data: rvalid=%b dout=%h, expected rvalid=1 dout=%h",
                 rvalid, dout, q[0].data);
      end
      void'(q.pop_front());
    end else if (rvalid !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL spurious_rvalid: rvalid=%b, expected 0", rvalid);
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endtask

  // Called at a negedge in IDLE; returns at the next negedge.
  task automatic drive_access(input logic w, input logic [7:0] a, input logic [7:0] d);
    req = 1'b1; we = w; addr = a; din = d;
    if (w) model[a] = d;
    else   q.push_back('{data: model[a], due: cyc + 1});
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  // Counts negedge samples with busy=1 while hammering req; optionally
  // pulses clr once mid-sweep at sample index clr_at.
  task automatic count_busy(input int clr_at, output int n);
    n = 0;
    req = 1'b1; we = 1'b0; addr = 8'h2A;
    while (busy === 1'b1 && n < 2000) begin
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_sweep: ready=%b at sweep cycle %0d, expected 0", ready, n);
      end
      clr = (n == clr_at);
      n++;
      @(negedge clk);
    end
    clr = 1'b0;
    req = 1'b0;
  endtask

  task automatic check_busy_len(input string name, input int n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL %s: busy cycles=%0d, expected %0d", name, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rvalid !== 1'b0 || dout !== 8'h00 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rvalid=%b dout=%h ready=%b, expected 1 0 00 0",
               busy, rvalid, dout, ready);
    end
    rst = 1'b0;
    clear_model();
    count_busy(-1, n);
    check_busy_len("reset_sweep_len", n);
    drive_access(1'b0, 8'h00, 8'h00);
    drive_access(1'b0, 8'h7F, 8'h00);
    drive_access(1'b0, 8'hFF, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_write_read();
    drive_access(1'b1, 8'h03, 8'hA5);
    checks++;
    if (taps[31:24] !== 8'hA5) begin
      errors++;
      $display("FAIL tap_word3: taps[31:24]=%h, expected a5", taps[31:24]);
    end
    drive_access(1'b0, 8'h03, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive_access(1'b1, 8'h10, 8'h11);
    drive_access(1'b1, 8'h11, 8'h22);
    drive_access(1'b1, 8'h12, 8'h33);
    drive_access(1'b0, 8'h10, 8'h00);
    drive_access(1'b0, 8'h11, 8'h00);
    drive_access(1'b0, 8'h12, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== 8'h33 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL dout_hold: dout=%h rvalid=%b, expected 33 0", dout, rvalid);
    end
  endtask

  task automatic test_clear_collision();
    int n;
    drive_access(1'b0, 8'h11, 8'h00);   // read accepted the cycle before clr
    clr = 1'b1; req = 1'b1; we = 1'b1; addr = 8'h05; din = 8'h77;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_on_clr: ready=%b, expected 0", ready);
    end
    @(negedge clk);
    clr = 1'b0; req = 1'b0; we = 1'b0;
    clear_model();
    count_busy(100, n);                 // clr mid-sweep must be ignored
    check_busy_len("clr_sweep_len", n);
    drive_access(1'b0, 8'h05, 8'h00);
    drive_access(1'b0, 8'h12, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int n;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (8'h40) @(negedge clk);      // sweep now at clr_addr 0x40
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    count_busy(-1, n);
    check_busy_len("reset_mid_sweep_len", n);
    drive_access(1'b1, 8'h20, 8'h3C);
    req = 1'b1; we = 1'b0; addr = 8'h20;
    @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_in_rvalid: rvalid=%b dout=%h, expected 0 00", rvalid, dout);
    end
    rst = 1'b0;
    clear_model();
    count_busy(-1, n);
    check_busy_len("reset_after_read_len", n);
  endtask

  task automatic test_param_corner();
    int n = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    while (p_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL corner_sweep_len: busy cycles=%0d, expected 16", n);
    end
    p_req = 1'b1; p_we = 1'b1; p_addr = 4'hF; p_din = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (p_taps[255:240] !== 16'hBEEF) begin
      errors++;
      $display("FAIL corner_tap15: taps[255:240]=%h, expected beef", p_taps[255:240]);
    end
    p_we = 1'b0;
    @(negedge clk);
    p_req = 1'b0;
    checks++;
    if (p_rvalid !== 1'b1 || p_dout !== 16'hBEEF) begin
      errors++;
      $display("FAIL corner_read: rvalid=%b dout=%h, expected 1 beef", p_rvalid, p_dout);
    end
    @(negedge clk);
    checks++;
    if (p_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL corner_rvalid_pulse: rvalid=%b, expected 0", p_rvalid);
    end
  endtask

  initial begin
    clear_model();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clear_collision();
    test_reset_mid_op();
    test_param_corner();
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_sweep.md
Name: data_mem_sweep

Overview:
- Parametrised successor to the team's single-port data memory.
- Generalises data width, depth and debug-tap count.
- Replaces the one-cycle full-array reset with a sequential clear sweep, so the array maps onto block RAM.
- Adds a ready/valid request interface, a registered read path, and a software-triggered clear. Sits between the CPU datapath load/store unit and the board debug display.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
N_TAP, 8, number of low-address words exported on the debug tap bus (1..DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  access request, qualified by ready
we  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDR_W  word address
din  in  DATA_W  write data
clr  in  1  one-cycle pulse: start a full-array clear sweep
ready  out  1  1 = request accepted this cycle if req=1
rvalid  out  1  read data valid pulse
dout  out  DATA_W  registered read data
busy  out  1  clear sweep in progress
taps  out  N_TAP*DATA_W  words 0..N_TAP-1, word k at bits [k*DATA_W +: DATA_W]

Behaviour:
- State machine, states CLEAR and IDLE. Clear counter clr_addr is ADDR_W bits wide.
- Reset: rst=1 asynchronously forces CLEAR, clr_addr=0, busy=1, rvalid=0, dout=0. Reset does not touch array contents directly; the sweep zeroes them.
- CLEAR state:
  - Each cycle writes 0 to mem[clr_addr], then increments clr_addr.
  - On the cycle that writes DEPTH-1, the next state is IDLE.
  - The sweep takes exactly DEPTH cycles after rst deasserts or after clr is taken. busy=1 throughout; busy falls in the first IDLE cycle.
  - ready=0 for the whole sweep. req is ignored and no rvalid is produced.
  - clr during CLEAR is ignored; the sweep continues.
- ready (combinational): ready = (state==IDLE) && !clr.
- Accepted access: a request is accepted on a rising edge with req && ready.
  - Write (we=1): mem[addr] <= din on that edge. No rvalid. dout is unchanged.
  - Read (we=0): dout <= mem[addr] on that edge, rvalid=1 for exactly that following cycle. Read latency is 1.
  - Back-to-back reads give rvalid on consecutive cycles.
  - One access per cycle; a write followed next cycle by a read of the same address returns the new data.
- clr in IDLE:
  - The next edge enters CLEAR with clr_addr=0, busy=1.
  - A req in the same cycle is not accepted, because ready=0.
  - rvalid from a read accepted in the previous cycle still pulses normally.
- rvalid defaults to 0 in every cycle without an accepted read.
- dout holds its last read value until the next accepted read. It is cleared only by rst, not by the clr sweep.
- taps: combinational view of mem[0..N_TAP-1]. A write is visible on taps from the cycle after its edge.
- Reset mid-sweep or mid-read: returns immediately to CLEAR at clr_addr=0. A pending rvalid is dropped (0).
- Address wrap: clr_addr wraps DEPTH-1 -> 0 only as the CLEAR exit. No out-of-range addresses exist, since addr is ADDR_W bits.
- Pre-sweep content of the array is undefined and must never be observable through dout or taps once busy=0.

Test Plan:
- Reset sweep: assert rst, release; count cycles with busy=1 -> exactly 256 for ADDR_W=8; ready=0 throughout; afterwards read addr 0x00, 0x7F, 0xFF -> dout=0x00, rvalid one cycle each.
- Write/read: write 0xA5 to 0x03, then read 0x03 on the next cycle -> rvalid in the cycle after the read edge with dout=0xA5; taps[31:24]=0xA5 from the cycle after the write.
- Back-to-back: write 0x11/0x22/0x33 to 0x10/0x11/0x12, then three consecutive reads -> rvalid high three cycles, dout 0x11, 0x22, 0x33 in order; dout holds 0x33 afterwards.
- Clear collision: in IDLE, pulse clr with req=1,we=1,addr=0x05,din=0x77 -> ready=0, write dropped; busy high 256 cycles; then read 0x05 -> 0x00; a read accepted the cycle before clr still returns its data.
- Reset mid-operation: start a sweep, assert rst at clr_addr=0x40 -> sweep restarts, busy stays 256 more cycles after release; rst in the rvalid cycle -> rvalid=0, dout=0.
- Parameter corner: DATA_W=16, ADDR_W=4, N_TAP=16 -> sweep 16 cycles; write 0xBEEF to 0xF -> taps[255:240]=0xBEEF, read 0xF returns 0xBEEF.
